// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling serial receiver (8N1) feeding an 8-entry FIFO with sticky error flags.
// Build option: define UART_RX_PARITY_EN for 8E1 framing with live parity checking.
module uart_rx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sin,
  input  logic       rd_req,
  input  logic       clr_err,
  output logic [7:0] rx_data,
  output logic       data_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  // state    | meaning
  // S_IDLE   | line idle, waiting for s=0
  // S_START  | validating start bit at its mid-point
  // S_DATA   | shifting in 8 data bits, LSB first
  // S_PARITY | checking even parity bit (UART_RX_PARITY_EN only)
  // S_STOP   | sampling stop bit, pushing byte on success
  // S_BREAK  | line held low after framing error, waiting for s=1
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif

  localparam int DIV_RAW = CLK_HZ / (16 * BAUD);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LOAD = DW'(DIV - 1);

  logic          s_meta;
  logic          s;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [3:0]    tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          discard;
  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic          start_det;
  logic          sample;
  logic          push;
  logic          set_fe;

  logic [7:0]    mem [8];
  logic [2:0]    wr_ptr;
  logic [2:0]    rd_ptr;
  logic [3:0]    count;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic          drop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_meta <= 1'b1;
      s      <= 1'b1;
    end else begin
      s_meta <= sin;
      s      <= s_meta;
    end
  end

  assign start_det = (state == S_IDLE) && !s;

  // Down-counter; reloading on the start edge phase-aligns all ticks to it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= DIV_LOAD;
    end else if (start_det || (div_cnt == '0)) begin
      div_cnt <= DIV_LOAD;
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

  assign tick   = (div_cnt == '0);
  assign sample = tick && (tick_cnt == 4'd7);

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    set_fe    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!s) state_nxt = S_START;
      end
      S_START: begin
        if (sample) state_nxt = s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (sample && (bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (sample) state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        if (sample) begin
          if (s) begin
            push      = !discard;
            state_nxt = S_IDLE;
          end else begin
            set_fe    = 1'b1;
            state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      tick_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
    end else begin
      state <= state_nxt;
      if (start_det) begin
        tick_cnt <= 4'd0;
        bit_cnt  <= 3'd0;
      end else if (tick) begin
        tick_cnt <= tick_cnt + 4'd1;
      end
      if ((state == S_DATA) && sample) begin
        shift   <= {s, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic set_pe;

  // Even parity: the parity bit equals the XOR of the data bits.
  assign set_pe = (state == S_PARITY) && sample && ((^shift) != s);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      discard <= 1'b0;
    end else if (start_det) begin
      discard <= 1'b0;
    end else if (set_pe) begin
      discard <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= set_pe | (parity_err & ~clr_err);
    end
  end
`else
  assign discard    = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign pop   = rd_req && (count != 4'd0);
  assign full  = (count == 4'd8);
  // When full, a simultaneous pop frees the head slot, which is exactly where wr_ptr points.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
      wr_ptr <= 3'd0;
      rd_ptr <= 3'd0;
      count  <= 4'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + 3'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 3'd1;
      case ({wr_en, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  assign rx_data    = mem[rd_ptr];
  assign data_ready = (count != 4'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= set_fe | (frame_err & ~clr_err);
      overrun   <= drop | (overrun & ~clr_err);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame stimulus with a queue-based reference FIFO and a decoupled read monitor.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 100000;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME_BITS = PAR ? 11 : 10;
  // Rising edge (counted from the falling start edge) of the stop-bit sample:
  // 2 sync + 1 into START + 8 ticks to the start mid-bit + 16 per later bit.
  localparam int STOP_EDGE = 3 + 8 + 16 * (FRAME_BITS - 1);

  logic       clk;
  logic       reset;
  logic       sin;
  logic       rd_req;
  logic       clr_err;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  logic       mon_rd;
  logic       stim_rd;
  logic       auto_read;

  logic [7:0] exp_q [$];
  bit         exp_fe;
  bit         exp_pe;
  bit         exp_ovr;
  int         n_checks;
  int         n_pass;

  assign rd_req = mon_rd | stim_rd;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk        (clk),
    .reset      (reset),
    .sin        (sin),
    .rd_req     (rd_req),
    .clr_err    (clr_err),
    .rx_data    (rx_data),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit par_good);
    logic [FRAME_BITS-1:0] bits;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    if (PAR) bits[9] = par_good ? ^d : ~^d;
    bits[FRAME_BITS-1] = stop_bit;
    for (int i = 0; i < FRAME_BITS; i++) begin
      sin = bits[i];
      repeat (16) @(negedge clk);
    end
  endtask

  // Reference model: a good frame enters the FIFO unless it is full.
  task automatic sched(input logic [7:0] d, input bit stop_bit, input bit par_good);
    bit good;
    good = stop_bit && (!PAR || par_good);
    if (good) begin
      if (exp_q.size() < 8) exp_q.push_back(d);
      else exp_ovr = 1'b1;
    end
    if (!stop_bit) exp_fe = 1'b1;
    if (PAR && !par_good) exp_pe = 1'b1;
    send_frame(d, stop_bit, par_good);
  endtask

  task automatic clear_errs();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    exp_fe  = 1'b0;
    exp_pe  = 1'b0;
    exp_ovr = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_empty"}, int'(data_ready), 0);
  endtask

  initial begin
    mon_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_rd) begin
        mon_rd = 1'b0;
      end else if (auto_read && data_ready) begin
        if (exp_q.size() == 0) check("unexpected_byte", int'(rx_data), 'h100);
        else check("rx_byte", int'(rx_data), int'(exp_q.pop_front()));
        mon_rd = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b0;
    sin       = 1'b1;
    stim_rd   = 1'b0;
    clr_err   = 1'b0;
    auto_read = 1'b0;
    exp_fe    = 1'b0;
    exp_pe    = 1'b0;
    exp_ovr   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rx_data", int'(rx_data), 0);
    check("rst_data_ready", int'(data_ready), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_parity_err", int'(parity_err), 0);
    check("rst_overrun", int'(overrun), 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte with latency bound and manual pop
    fork
      sched(8'h55, 1'b1, 1'b1);
      begin
        lat = 0;
        while (!data_ready && lat < 300) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("latency_within_bound", int'(lat <= STOP_EDGE + 1), 1);
    check("single_rx_data", int'(rx_data), int'(exp_q.pop_front()));
    stim_rd = 1'b1;
    @(negedge clk);
    stim_rd = 1'b0;
    check("single_pop_empty", int'(data_ready), 0);
    check("single_no_fe", int'(frame_err), int'(exp_fe));
    check("single_no_ovr", int'(overrun), int'(exp_ovr));

    // Start glitch
    auto_read = 1'b1;
    sin = 1'b0;
    repeat (4) @(negedge clk);
    sin = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_byte", int'(data_ready), 0);
    check("glitch_no_fe", int'(frame_err), 0);
    sched(8'hC3, 1'b1, 1'b1);
    drain("glitch_follow");

    // Framing error with held-low line
    sched(8'hA3, 1'b0, 1'b1);
    repeat (40) @(negedge clk);
    check("fe_set", int'(frame_err), int'(exp_fe));
    check("fe_no_byte", int'(data_ready), 0);
    clear_errs();
    repeat (20) @(negedge clk);
    check("fe_single_event", int'(frame_err), int'(exp_fe));
    sin = 1'b1;
    repeat (20) @(negedge clk);
    sched(8'h01, 1'b1, 1'b1);
    drain("fe_recover");

    // Overrun: nine frames, no reads
    auto_read = 1'b0;
    for (int i = 0; i < 9; i++) sched(8'(i), 1'b1, 1'b1);
    check("ovr_set", int'(overrun), int'(exp_ovr));
    check("ovr_ready", int'(data_ready), 1);
    auto_read = 1'b1;
    drain("ovr_reads");
    clear_errs();
    check("ovr_cleared", int'(overrun), 0);

    // Full FIFO with pop in the same cycle as a push
    auto_read = 1'b0;
    for (int i = 0; i < 8; i++) sched(8'(8'h10 + i), 1'b1, 1'b1);
    fork
      send_frame(8'h5A, 1'b1, 1'b1);
      begin
        repeat (STOP_EDGE - 1) @(negedge clk);
        check("full_head", int'(rx_data), int'(exp_q.pop_front()));
        stim_rd = 1'b1;
        @(negedge clk);
        stim_rd = 1'b0;
      end
    join
    exp_q.push_back(8'h5A);
    check("full_no_ovr", int'(overrun), 0);
    auto_read = 1'b1;
    drain("full_reads");

`ifdef UART_RX_PARITY_EN
    sched(8'h07, 1'b1, 1'b1);
    drain("par_good");
    check("par_good_no_err", int'(parity_err), 0);
    sched(8'h07, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check("par_bad_err", int'(parity_err), int'(exp_pe));
    check("par_bad_discard", int'(data_ready), 0);
    clear_errs();
`endif

    // Randomized traffic
    for (int k = 0; k < 24; k++) begin
      logic [7:0] d;
      bit pg;
      int gap;
      d   = 8'($urandom);
      pg  = PAR ? ($urandom_range(0, 4) != 0) : 1'b1;
      gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 30));
      sched(d, 1'b1, pg);
      repeat (gap) @(negedge clk);
    end
    drain("random");
    check("random_pe", int'(parity_err), int'(exp_pe));
    check("random_fe", int'(frame_err), int'(exp_fe));
    clear_errs();

    // Reset mid-frame with queued bytes and a pending flag
    auto_read = 1'b0;
    sched(8'h33, 1'b1, 1'b1);
    sched(8'h44, 1'b1, 1'b1);
    sched(8'hEE, 1'b0, 1'b1);
    sin = 1'b1;
    repeat (20) @(negedge clk);
    check("pre_reset_fe", int'(frame_err), int'(exp_fe));
    check("pre_reset_ready", int'(data_ready), 1);
    sin = 1'b0;
    repeat (60) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_fe = 1'b0;
    exp_pe = 1'b0;
    exp_ovr = 1'b0;
    check("mid_rst_rx_data", int'(rx_data), 0);
    check("mid_rst_ready", int'(data_ready), 0);
    check("mid_rst_fe", int'(frame_err), 0);
    check("mid_rst_pe", int'(parity_err), 0);
    check("mid_rst_ovr", int'(overrun), 0);
    sin = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    auto_read = 1'b1;
    sched(8'h99, 1'b1, 1'b1);
    drain("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that complements the transmit-only `uart` block used by the memory controller. It samples the asynchronous `sin` line at 16x the baud rate and decodes 8N1 frames, or 8E1 frames when parity is configured in. Decoded bytes go into an 8-entry FIFO that the memory controller pops through a strobe interface. Framing, parity and overrun errors are reported on sticky flags.

## Interface
- CLK_HZ, 50000000, system clock frequency in Hz
- BAUD, 115200, serial bit rate
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- sin  in  1  serial input, idle high, asynchronous to clk
- rd_req  in  1  one-cycle pop strobe for the FIFO head
- clr_err  in  1  clears all sticky error flags
- rx_data  out  8  FIFO head byte; valid while data_ready=1
- data_ready  out  1  FIFO not empty
- frame_err  out  1  sticky; stop bit sampled 0
- parity_err  out  1  sticky; parity mismatch (constant 0 without UART_RX_PARITY_EN)
- overrun  out  1  sticky; byte dropped because FIFO full

## Operation
- Synchronizer: 2-flop on `sin`, reset value 1. All decoding uses the synchronized value `s`.
- Tick generator: DIV = CLK_HZ/(16*BAUD), integer truncation, minimum 1. It emits a one-cycle tick every DIV clocks and is reloaded when a start edge is detected.
- Tick counter: 4 bits, wraps 15->0. Bit counter: 3 bits.
- FSM states and transitions:
  - IDLE: on s=0, clear the tick and bit counters and go to START.
  - START: at tick 7 (mid-bit), sample s. s=0 goes to DATA; s=1 is a glitch, go to IDLE with no flag.
  - DATA: every 16 ticks, sample s and shift it in LSB-first. After bit 7, go to PARITY if configured, else STOP.
  - PARITY: sample after 16 ticks. Even parity: XOR of the 8 data bits must equal the sampled bit. A mismatch sets parity_err and marks the byte for discard. Go to STOP.
  - STOP: sample after 16 ticks. s=1: push the byte unless it is marked for discard, then go to IDLE. s=0: set frame_err, discard the byte, go to BREAK.
  - BREAK: wait for s=1, then go to IDLE. A held-low line produces exactly one frame_err.
- FIFO:
  - 8 entries, 3-bit read and write pointers, 4-bit count, pointers wrap modulo 8.
  - rx_data is the entry at the read pointer, presented combinationally from registered storage.
  - rd_req with data_ready=0 is ignored.
  - Push with count=8 and no rd_req: the byte is dropped and overrun is set.
  - Push and rd_req in the same cycle at count=8: both succeed, count stays 8, no overrun.
  - Push and rd_req in the same cycle at any other count: count is unchanged.
- Error flags: set takes priority over clr_err in the same cycle.
- Reset mid-frame: FSM returns to IDLE, FIFO is emptied, the partial byte is lost.

## Timing
- Reset values: rx_data=0x00, data_ready=0, frame_err=0, parity_err=0, overrun=0, FSM=IDLE.
- Start detection: 2 synchronizer cycles after the falling edge of `sin`, plus 1 cycle into START.
- Sample points: every bit is sampled at tick 7 of its 16-tick window, referenced to the detected start edge.
- Frame latency: data_ready and rx_data update on the clock after the stop-bit sample. That sample lands at the middle of the stop bit, about 9.5 bit times (8N1) or 10.5 bit times (8E1) after the start edge, plus 3 clocks.
- Pop: rd_req at cycle N advances the head at N+1, and data_ready updates at N+1.
- Flags: error flags assert 1 cycle after the offending sample.
- Back-to-back frames: a new start bit is accepted immediately after the stop-bit sample, which allows for up to 0.5 bit of transmitter clock skew.

## Configuration
- UART_RX_PARITY_EN
  - Defined: 8E1 framing. The PARITY state is present and parity_err is live.
  - Undefined: 8N1 framing. The PARITY state is removed, STOP follows DATA, and parity_err is tied to 0.

## Test plan
All scenarios use CLK_HZ=1600000 and BAUD=100000, so DIV=1 and each bit is 16 clocks.
- Single byte: send 0x55 (8N1) -> data_ready=1 no later than 156 clocks after the start edge, rx_data=0x55; pulse rd_req -> data_ready=0 next cycle; no flags set.
- Start glitch: drive `sin` low for 4 clocks on an idle line -> no byte received, no flag set; a following 0xC3 frame is received correctly.
- Framing error: send 0xA3 with stop bit 0, then hold the line low for 40 clocks -> exactly one frame_err, data_ready stays 0. Pulse clr_err -> frame_err=0. Release the line, send 0x01 -> rx_data=0x01.
- Overrun: send 0x00..0x08 without reading -> overrun=1. Eight reads return 0x00..0x07 in order, then data_ready=0.
- Full FIFO: with 8 bytes queued, pulse rd_req in the same cycle as the push of 0x5A -> overrun stays 0, count stays 8, and the last read returns 0x5A. Assert reset mid-frame -> all outputs return to reset values.
- Parity (UART_RX_PARITY_EN defined): 0x07 with parity bit 1 -> accepted. 0x07 with parity bit 0 -> parity_err=1 and the byte is discarded.
